// File: rtl/uart_transceiver.sv
// uart_transceiver: 8N1 UART serializer/deserializer for the core's
// memory-mapped UART registers. TX and RX run independently, each with a
// private clock divider and oversample tick counter restarted per frame.
module uart_transceiver #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       uart_tx,
  input  logic [7:0] tx_data,
  input  logic       tx_en,
  output logic       tx_status,
  output logic [7:0] rx_data,
  output logic       rx_eff,
  input  logic       rx_read,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam int DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TICK_W = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // ---------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------
  tx_state_e          tx_state_q, tx_state_d;
  logic [DIV_W-1:0]   tx_div_q, tx_div_d;
  logic [TICK_W-1:0]  tx_tick_q, tx_tick_d;
  logic [2:0]         tx_idx_q, tx_idx_d;
  logic [7:0]         tx_shift_q, tx_shift_d;
  logic               uart_tx_q, uart_tx_d;
  logic               tx_bit_end;

  assign tx_bit_end = (tx_div_q == DIV_LAST) && (tx_tick_q == TICK_LAST);
  assign tx_status  = (tx_state_q == TX_IDLE);
  assign uart_tx    = uart_tx_q;

  // TX state register and datapath flops; the line is registered so it is glitch-free
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_div_q   <= '0;
      tx_tick_q  <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      uart_tx_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_div_q   <= tx_div_d;
      tx_tick_q  <= tx_tick_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      uart_tx_q  <= uart_tx_d;
    end
  end

  // TX next-state: each non-idle state lasts exactly one bit time
  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE:  if (tx_en) tx_state_d = TX_START;
      TX_START: if (tx_bit_end) tx_state_d = TX_DATA;
      TX_DATA:  if (tx_bit_end && (tx_idx_q == 3'd7)) tx_state_d = TX_STOP;
      TX_STOP:  if (tx_bit_end) tx_state_d = TX_IDLE;
      default:  tx_state_d = TX_IDLE;
    endcase
  end

  // TX outputs and counters; the line value is decoded from the next state
  always_comb begin
    tx_div_d   = tx_div_q;
    tx_tick_d  = tx_tick_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    if (tx_state_q == TX_IDLE) begin
      tx_div_d  = '0;
      tx_tick_d = '0;
      tx_idx_d  = '0;
      if (tx_en) tx_shift_d = tx_data;
    end else begin
      if (tx_div_q == DIV_LAST) begin
        tx_div_d  = '0;
        tx_tick_d = (tx_tick_q == TICK_LAST) ? '0 : tx_tick_q + TICK_W'(1);
      end else begin
        tx_div_d = tx_div_q + DIV_W'(1);
      end
      if ((tx_state_q == TX_DATA) && tx_bit_end) begin
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        tx_idx_d   = tx_idx_q + 3'd1;
      end
    end
    case (tx_state_d)
      TX_START: uart_tx_d = 1'b0;
      TX_DATA:  uart_tx_d = tx_shift_d[0];
      default:  uart_tx_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------
  rx_state_e          rx_state_q, rx_state_d;
  logic               rx_meta_q, rx_sync_q;
  logic               rx_armed_q, rx_armed_d;
  logic [DIV_W-1:0]   rx_div_q, rx_div_d;
  logic [TICK_W-1:0]  rx_tick_q, rx_tick_d;
  logic [2:0]         rx_idx_q, rx_idx_d;
  logic [7:0]         rx_shift_q, rx_shift_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               rx_eff_q, rx_eff_d;
  logic               rx_overrun_q, rx_overrun_d;
  logic               rx_frame_err_q, rx_frame_err_d;
  logic               rx_sample;
  logic               rx_byte_done;

  assign rx_sample = (rx_div_q == DIV_LAST) &&
                     (rx_tick_q == ((rx_state_q == RX_START) ? TICK_HALF : TICK_LAST));

  assign rx_data      = rx_data_q;
  assign rx_eff       = rx_eff_q;
  assign rx_overrun   = rx_overrun_q;
  assign rx_frame_err = rx_frame_err_q;

  // RX synchronizer, state register and receive datapath flops
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q      <= 1'b1;
      rx_sync_q      <= 1'b1;
      rx_armed_q     <= 1'b0;
      rx_state_q     <= RX_IDLE;
      rx_div_q       <= '0;
      rx_tick_q      <= '0;
      rx_idx_q       <= '0;
      rx_shift_q     <= '0;
      rx_data_q      <= '0;
      rx_eff_q       <= 1'b0;
      rx_overrun_q   <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      rx_meta_q      <= uart_rx;
      rx_sync_q      <= rx_meta_q;
      rx_armed_q     <= rx_armed_d;
      rx_state_q     <= rx_state_d;
      rx_div_q       <= rx_div_d;
      rx_tick_q      <= rx_tick_d;
      rx_idx_q       <= rx_idx_d;
      rx_shift_q     <= rx_shift_d;
      rx_data_q      <= rx_data_d;
      rx_eff_q       <= rx_eff_d;
      rx_overrun_q   <= rx_overrun_d;
      rx_frame_err_q <= rx_frame_err_d;
    end
  end

  // RX next-state: a start edge only counts once the line has been seen high
  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE:  if (rx_armed_q && !rx_sync_q) rx_state_d = RX_START;
      RX_START: if (rx_sample) rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_sample && (rx_idx_q == 3'd7)) rx_state_d = RX_STOP;
      RX_STOP:  if (rx_sample) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  // RX counters, bit sampling and the core-facing byte/flag handshake
  always_comb begin
    rx_armed_d     = rx_armed_q;
    rx_div_d       = rx_div_q;
    rx_tick_d      = rx_tick_q;
    rx_idx_d       = rx_idx_q;
    rx_shift_d     = rx_shift_q;
    rx_byte_done   = 1'b0;
    rx_frame_err_d = 1'b0;
    if (rx_state_q == RX_IDLE) begin
      rx_div_d   = '0;
      rx_tick_d  = '0;
      rx_idx_d   = '0;
      rx_armed_d = (rx_armed_q | rx_sync_q) && (rx_state_d == RX_IDLE);
    end else begin
      rx_armed_d = 1'b0;
      if (rx_div_q == DIV_LAST) begin
        rx_div_d  = '0;
        rx_tick_d = rx_sample ? '0 : rx_tick_q + TICK_W'(1);
      end else begin
        rx_div_d = rx_div_q + DIV_W'(1);
      end
      if ((rx_state_q == RX_DATA) && rx_sample) begin
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        rx_idx_d   = rx_idx_q + 3'd1;
      end
      if ((rx_state_q == RX_STOP) && rx_sample) begin
        rx_byte_done   = rx_sync_q;
        rx_frame_err_d = !rx_sync_q;
      end
    end

    rx_data_d    = rx_data_q;
    rx_eff_d     = rx_eff_q;
    rx_overrun_d = rx_overrun_q;
    if (rx_read) begin
      rx_eff_d     = 1'b0;
      rx_overrun_d = 1'b0;
    end
    if (rx_byte_done) begin
      rx_data_d = rx_shift_q;
      rx_eff_d  = 1'b1;
      if (rx_eff_q && !rx_read) rx_overrun_d = 1'b1;
    end
  end

endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
- 8N1 UART serializer/deserializer. Sits directly downstream of the pipeline core's memory-mapped UART registers.
- Consumes the core's transmit byte and transmit-enable strobe, and drives the serial TX line.
- Deserializes the RX line into a byte plus a valid flag that the core polls and acknowledges.
- All handshakes are single-clock strobes in the core clock domain.

Parameters:
- CLK_FREQ, 50000000, core clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- OVERSAMPLE, 16, ticks per bit (even, >=4).
- Derived: DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer floor, must be >=1. Bit time = DIV*OVERSAMPLE clocks exactly.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- uart_rx  in  1  serial input, asynchronous to clk.
- uart_tx  out  1  serial output, idle high.
- tx_data  in  8  byte to send (core UART_TXD).
- tx_en  in  1  one-cycle send strobe (core TX_EN).
- tx_status  out  1  1 = transmitter idle and able to accept a byte.
- rx_data  out  8  last received byte (core UART_RXD).
- rx_eff  out  1  1 = rx_data holds an unread byte (core RX_EFF).
- rx_read  in  1  one-cycle acknowledge from core (core RX_READ).
- rx_overrun  out  1  sticky: a byte was overwritten before being read.
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset values (cycle after reset is sampled high):
  - uart_tx=1, tx_status=1, rx_data=0, rx_eff=0, rx_overrun=0, rx_frame_err=0.
  - Both FSMs return to IDLE and all counters clear.
  - Reset mid-frame aborts the frame; uart_tx returns to 1 immediately.
- Tick generation: TX and RX each have a private divider (0..DIV-1) and tick counter (0..OVERSAMPLE-1).
  - Each divider restarts at the start of its frame, so bit edges are cycle-exact relative to frame start.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: uart_tx=1, tx_status=1.
  - tx_en=1 in IDLE: latch tx_data into shift register, go to START.
  - From the next cycle: uart_tx=0, tx_status=0.
  - tx_en while tx_status=0 is ignored; the byte is not queued.
  - START lasts one bit time, then DATA.
  - DATA: 8 bits, LSB first, one bit time each; a 3-bit index counts 0..7.
  - STOP: uart_tx=1 for one bit time, then IDLE.
  - tx_status returns to 1 on the first cycle after the stop bit completes.
  - Total busy time = 10 bit times.
  - A tx_en arriving in that first idle cycle is accepted (back-to-back frames, no gap).
- RX synchronizer: 2-flop synchronizer on uart_rx, both flops reset to 1. FSM uses the synchronized value only.
- RX FSM, states IDLE, START, DATA, STOP:
  - IDLE: synchronized rx==0 -> START; restart RX divider.
  - START: after OVERSAMPLE/2 ticks (bit midpoint), sample.
    - 0 -> DATA.
    - 1 -> IDLE (glitch rejected, nothing reported).
  - DATA: sample every OVERSAMPLE ticks at midpoints; 8 samples shifted in LSB first.
  - STOP: sample after OVERSAMPLE ticks.
    - 1: rx_data <= shifted byte, rx_eff <= 1 (same cycle).
    - 0: rx_frame_err pulses for 1 cycle; rx_data and rx_eff unchanged.
  - After either STOP outcome: return to IDLE.
  - IDLE re-arms only after synchronized rx has been seen high at least once (no false start on a stuck-low line).
- Receive handshake:
  - rx_read=1 clears rx_eff and rx_overrun next cycle.
  - A byte completing while rx_eff=1 and rx_read=0: rx_data overwritten, rx_eff stays 1, rx_overrun set.
  - Byte completion and rx_read in the same cycle: new byte wins. rx_eff=1, rx_data=new, rx_overrun cleared (not set).
  - rx_read while rx_eff=0: no effect.
- TX and RX are fully independent; loopback (uart_tx tied to uart_rx) must work.

Test Plan:
- Setup for all scenarios: CLK_FREQ=1600000, BAUD=100000, OVERSAMPLE=16, so DIV=1 and bit time = 16 clk.
- 1. Reset, then tx_en with tx_data=0xA5 at cycle 0 -> tx_status=0 from cycle 1; uart_tx=0 for cycles 1-16; bits 1,0,1,0,0,1,0,1 each 16 clk; then 1 for 16 clk; tx_status=1 at cycle 161.
- 2. tx_en with 0x3C during frame 1 -> ignored. tx_en with 0x3C at cycle 161 -> second frame starts at cycle 162 with no idle gap; line shows only 0xA5 then 0x3C.
- 3. Loopback, send 0x5A -> rx_eff rises with rx_data=0x5A. Pulse rx_read -> rx_eff=0 next cycle; rx_overrun stays 0.
- 4. Loopback, send 0x11 then 0x22 without rx_read -> rx_data=0x22, rx_eff=1, rx_overrun=1. Then rx_read -> both flags clear.
- 5. Drive uart_rx low for 6 clk then high -> no rx_eff, no rx_frame_err. Drive a full frame of 0xFF with the stop bit low -> rx_frame_err pulses once; rx_data keeps its previous value.
- 6. Assert reset at cycle 50 of an 0xFF transmit -> uart_tx=1 and tx_status=1 the next cycle. Complete the rx_read/new-byte same-cycle case -> rx_eff=1 and new rx_data.
